// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared sid widths and amplifier state encoding
package sid_pkg;
  localparam int WAVE_W = 12;
  localparam int ENV_W  = 8;
  localparam int OUT_W  = WAVE_W + ENV_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    HOLD = 2'd2
  } amp_state_e;
endpackage

// File: rtl/sid_serial_mul.sv
// rtl/sid_serial_mul.sv - shift-add signed(wave) x unsigned(env) multiplier, one env bit per cycle
module sid_serial_mul #(
  parameter int WAVE_W = 12,
  parameter int ENV_W  = 8,
  parameter int OUT_W  = WAVE_W + ENV_W,
  parameter int CNT_W  = $clog2(ENV_W + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [WAVE_W-1:0] wave_i,
  input  logic [ENV_W-1:0]  env_i,
  output logic              done_o,
  output logic [OUT_W-1:0]  product_o
);
  logic [OUT_W-1:0] swave_q, swave_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      swave_q  <= '0;
      acc_q    <= '0;
      env_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      swave_q  <= swave_d;
      acc_q    <= acc_d;
      env_q    <= env_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    swave_d  = swave_q;
    acc_d    = acc_q;
    env_d    = env_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_o   = active_q && (cnt_q == CNT_W'(ENV_W));
    if (start_i) begin
      // Inverting the MSB re-centres the midscale-0x800 wave to two's complement.
      swave_d  = OUT_W'($signed({~wave_i[WAVE_W-1], wave_i[WAVE_W-2:0]}));
      env_d    = env_i;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (done_o) begin
        active_d = 1'b0;
      end else begin
        if (env_q[0]) acc_d = acc_q + (swave_q << cnt_q);
        env_d = env_q >> 1;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign product_o = acc_q;
endmodule

// File: rtl/sid_voice_amp.sv
// rtl/sid_voice_amp.sv - voice amplitude scaler: capture/multiply/hold FSM with valid-ready output
module sid_voice_amp #(
  parameter int WAVE_W = sid_pkg::WAVE_W,
  parameter int ENV_W  = sid_pkg::ENV_W,
  localparam int OUT_W = WAVE_W + ENV_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [WAVE_W-1:0] wave,
  input  logic [ENV_W-1:0]  env,
  input  logic              voice_mute,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);
  import sid_pkg::*;

  localparam int CNT_W = $clog2(ENV_W + 1);

  amp_state_e       state_q, state_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             mute_q, mute_d;
  logic             mul_start;
  logic             mul_done;
  logic [OUT_W-1:0] mul_product;
  logic             xfer;

  sid_serial_mul #(
    .WAVE_W(WAVE_W),
    .ENV_W (ENV_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (mul_start),
    .wave_i   (wave),
    .env_i    (env),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  assign xfer = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      mute_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      mute_q      <= mute_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    mute_d      = mute_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          mul_start = 1'b1;
          mute_d    = voice_mute;
          state_d   = MULT;
        end
      end
      MULT: begin
        if (sample_tick) overrun_d = 1'b1;
        if (mul_done) begin
          out_valid_d = 1'b1;
          out_data_d  = mute_q ? '0 : mul_product;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_data_d  = '0;
          // A tick coinciding with the transfer chains straight into the next multiply.
          if (sample_tick) begin
            mul_start = 1'b1;
            mute_d    = voice_mute;
            state_d   = MULT;
          end else begin
            state_d = IDLE;
          end
        end else if (sample_tick) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_sid_voice_amp.sv
// tb/tb_sid_voice_amp.sv - self-checking bench for sid_voice_amp
module tb_sid_voice_amp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [11:0] wave = '0;
  logic [7:0]  env = '0;
  logic        voice_mute = 1'b0;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_fail = 0;

  sid_voice_amp dut (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .wave       (wave),
    .env        (env),
    .voice_mute (voice_mute),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] w;
    logic [7:0]  e;
    logic        m;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [11:0] w, input logic [7:0] e, input logic m);
    int p;
    p = (int'({20'd0, w}) - 2048) * int'({24'd0, e});
    return m ? 20'd0 : p[19:0];
  endfunction

  task automatic wait_valid(input bit wobble, input int start_k, output int lat);
    lat = -1;
    for (int k = start_k; k <= 30; k++) begin
      if (wobble) begin
        wave       = 12'($urandom);
        env        = 8'($urandom);
        voice_mute = 1'($urandom);
      end
      step();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_sample(input logic [11:0] w, input logic [7:0] e, input logic m,
                            input bit wobble, output logic [19:0] data, output int lat);
    wave        = w;
    env         = e;
    voice_mute  = m;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("busy_after_tick", 32'(busy), 32'd1);
    wait_valid(wobble, 1, lat);
    data = out_data;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("data_zero_idle", 32'(out_data), 32'd0);
  endtask

  initial begin
    logic [19:0] d;
    logic [19:0] hold_d;
    int          lat;

    tbl[0] = '{12'hFFF, 8'hFF, 1'b0, 20'h7F701};
    tbl[1] = '{12'h000, 8'hFF, 1'b0, 20'h80800};
    tbl[2] = '{12'h800, 8'hFF, 1'b0, 20'h00000};
    tbl[3] = '{12'hFFF, 8'h00, 1'b0, 20'h00000};
    tbl[4] = '{12'hFFF, 8'h80, 1'b1, 20'h00000};
    tbl[5] = '{12'h000, 8'h01, 1'b0, 20'hFF800};
    tbl[6] = '{12'h801, 8'hFF, 1'b0, 20'h000FF};

    step();
    step();
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_sample(tbl[i].w, tbl[i].e, tbl[i].m, 1'b0, d, lat);
      check("tbl_latency", 32'(lat), 32'd9);
      check("tbl_data", 32'(d), 32'(tbl[i].exp));
      drain();
    end
    check("tbl_overrun", 32'(overrun), 32'd0);

    run_sample(12'hFFF, 8'hFF, 1'b0, 1'b0, d, lat);
    check("stall_latency", 32'(lat), 32'd9);
    for (int k = 0; k < 20; k++) begin
      wave = 12'($urandom);
      env  = 8'($urandom);
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h7F701);
    end
    drain();

    run_sample(12'hFFF, 8'hFF, 1'b0, 1'b0, d, lat);
    wave        = 12'h000;
    env         = 8'h10;
    out_ready   = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    out_ready   = 1'b0;
    check("chain_valid_low", 32'(out_valid), 32'd0);
    check("chain_busy", 32'(busy), 32'd1);
    check("chain_overrun", 32'(overrun), 32'd0);
    wait_valid(1'b1, 1, lat);
    check("chain_latency", 32'(lat), 32'd9);
    check("chain_data", 32'(out_data), 32'hF8000);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("hold_tick_overrun", 32'(overrun), 32'd1);
    check("hold_tick_data", 32'(out_data), 32'hF8000);
    check("hold_tick_valid", 32'(out_valid), 32'd1);
    drain();

    wave        = 12'hFFF;
    env         = 8'hFF;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_sample(12'h123, 8'h5A, 1'b0, 1'b0, d, lat);
    check("postrst_latency", 32'(lat), 32'd9);
    check("postrst_data", 32'(d), 32'(model(12'h123, 8'h5A, 1'b0)));
    drain();

    wave        = 12'hFFF;
    env         = 8'hFF;
    voice_mute  = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    step();
    wave        = 12'h000;
    env         = 8'h01;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("mult_tick_overrun", 32'(overrun), 32'd1);
    wait_valid(1'b0, 5, lat);
    check("mult_tick_latency", 32'(lat), 32'd9);
    check("mult_tick_data", 32'(out_data), 32'h7F701);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [11:0] w;
      logic [7:0]  e;
      logic        m;
      w = 12'($urandom);
      e = 8'($urandom);
      m = ($urandom_range(0, 3) == 0);
      run_sample(w, e, m, 1'b1, d, lat);
      check("rand_latency", 32'(lat), 32'd9);
      check("rand_data", 32'(d), 32'(model(w, e, m)));
      hold_d = d;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        step();
        check("rand_hold", 32'(out_data), 32'(hold_d));
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sid_voice_amp.md
SID_VOICE_AMP -- requirements
Module: sid_voice_amp

Interface
REQ-001 Parameter WAVE_W, default 12, oscillator waveform width, unsigned.
REQ-002 Parameter ENV_W, default 8, envelope width; also the number of multiply iterations.
REQ-003 Derived constant OUT_W = WAVE_W+ENV_W (20), signed product width.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sample_tick  input  1  one-cycle request to capture inputs and start a multiply.
REQ-007 wave  input  WAVE_W  unsigned oscillator output, midscale 0x800.
REQ-008 env  input  ENV_W  envelope level from sid_env out.
REQ-009 voice_mute  input  1  when high, the result is forced to zero.
REQ-010 out_data  output  OUT_W  signed two's-complement amplitude-scaled sample.
REQ-011 out_valid  output  1  out_data valid, held until accepted.
REQ-012 out_ready  input  1  consumer (voice mixer) accepts when high with out_valid.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 overrun  output  1  sticky flag: a sample_tick was dropped.

Function
REQ-015 FSM states SHALL be IDLE, MULT and HOLD.
REQ-016 IDLE with sample_tick: capture swave = wave with MSB inverted (wave-0x800, sign-extended to OUT_W), env, and voice_mute; clear accumulator and iteration count; go to MULT.
REQ-017 MULT: each cycle, if the env shift register LSB is 1, add swave<<count to the accumulator (OUT_W-bit, no saturation), shift env right, and increment count.
REQ-018 After exactly ENV_W MULT cycles, go to HOLD, load out_data with the accumulator (zero if the captured mute is set), and assert out_valid.
REQ-019 Latency: sample_tick sampled at edge N gives out_valid high after edge N+1+ENV_W (N+9 by default).
REQ-020 HOLD: out_data and out_valid SHALL remain stable until out_valid && out_ready.
REQ-021 Transfer in HOLD without sample_tick: deassert out_valid next cycle and go to IDLE.
REQ-022 Transfer and sample_tick in the same HOLD cycle: complete the transfer, capture new inputs, and go directly to MULT; no overrun.
REQ-023 sample_tick in MULT, or in HOLD without transfer: ignore the tick, set overrun, and leave the current operation unaffected.
REQ-024 overrun SHALL clear only on reset.
REQ-025 Changes to wave, env or voice_mute after capture SHALL NOT affect the in-flight result.
REQ-026 env=0 SHALL yield 0; the extremes ±2047/-2048 × 255 SHALL fit in OUT_W without overflow.
REQ-027 out_data SHALL be zero whenever out_valid is low.

Reset
REQ-028 Asserting reset, at any state including mid-MULT, SHALL immediately set state=IDLE, out_data=0, out_valid=0, busy=0, overrun=0, and clear the accumulator, count and captured registers.
REQ-029 In the first cycle after reset deasserts, the block SHALL accept sample_tick normally.

Structure
REQ-030 WAVE_W, ENV_W, OUT_W and the state encodings (IDLE=0, MULT=1, HOLD=2) SHALL live in the shared sid constants package/include used by the sid_* blocks.
REQ-031 The shift-add datapath (accumulator, env shifter, counter) SHALL be one sub-module, sid_serial_mul, with start/done; sid_voice_amp holds the FSM, handshake and overrun logic.

Verification
REQ-032 wave=0xFFF, env=0xFF, tick, out_ready=1 -> out_data=0x7F701 (521985), out_valid rises 9 cycles after tick.
REQ-033 wave=0x000, env=0xFF -> out_data=0x80800 (-522240); wave=0x800, env=0xFF -> 0; wave=0xFFF, env=0x00 -> 0.
REQ-034 out_ready=0 for 20 cycles after valid, with wave/env changing -> out_data/out_valid stable; ready=1 -> valid drops next cycle, busy=0.
REQ-035 Tick at cycle 3 of MULT -> overrun=1 and result unchanged; tick with ready in the HOLD transfer cycle -> next result after 9 cycles, overrun unchanged.
REQ-036 wave=0xFFF, env=0x80, voice_mute=1 at tick -> out_data=0; reset pulse mid-MULT -> all outputs 0 immediately, next tick works normally.
